fp_to_int_converter: RTL and testbench



---
 rtl/fp_pkg.sv | 24 ++
 rtl/fp_shift_unit.sv | 49 ++++
 rtl/fp_to_int_converter.sv | 150 +++++++++++++++
 tb/tb_fp_to_int_converter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point datapath.
// Field layout, exponent bias, status codes and converter FSM states.
package fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 25;
  localparam int FRAC_W   = 25;
  localparam int EXP_BIAS = 31;

  localparam logic [3:0] ST_EXACT   = 4'd0;
  localparam logic [3:0] ST_OVF     = 4'd1;
  localparam logic [3:0] ST_UNF     = 4'd2;
  localparam logic [3:0] ST_INEXACT = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLASSIFY = 3'd1,
    S_SHIFT    = 3'd2,
    S_FINISH   = 3'd3,
    S_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/fp_shift_unit.sv
// Significand accumulator with a 1-bit-per-cycle shifter.
// Counts down the shift distance and collects lost bits in sticky.
module fp_shift_unit (
  input  logic        clock_100kHz,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] acc_in,
  input  logic        arm,
  input  logic [4:0]  cnt_in,
  input  logic        dir_right,
  input  logic        step,
  output logic [31:0] acc,
  output logic        sticky,
  output logic        done
);

  logic [4:0] cnt;
  logic       right;

  // Load significand, arm count/direction, then shift one bit per step.
  always_ff @(posedge clock_100kHz or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      cnt    <= '0;
      right  <= 1'b0;
      sticky <= 1'b0;
    end else begin
      if (load) acc <= acc_in;
      if (arm) begin
        cnt    <= cnt_in;
        right  <= dir_right;
        sticky <= 1'b0;
      end
      if (step && cnt != 5'd0) begin
        if (right) begin
          acc    <= acc >> 1;
          sticky <= sticky | acc[0];
        end else begin
          acc <= acc << 1;
        end
        cnt <= cnt - 5'd1;
      end
    end
  end

  // The step taken while the count is one is the last.
  assign done = (cnt == 5'd1);

endmodule

// File: rtl/fp_to_int_converter.sv
// Float result word to signed 32-bit integer, truncating toward zero.
// Iterative: classify, shift one bit per cycle, then sign/saturate.
module fp_to_int_converter #(
  parameter int EXP_BIAS = 31,
  parameter int OUT_W    = 32
) (
  input  logic             clock_100kHz,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      data_in,
  input  logic [3:0]       status_in,
  output logic [OUT_W-1:0] int_out,
  output logic [3:0]       status_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       state_dbg
);

  import fp_pkg::*;

  localparam logic [1:0] P_NORM = 2'd0;
  localparam logic [1:0] P_SAT  = 2'd1;
  localparam logic [1:0] P_ZERO = 2'd2;

  localparam logic [5:0] BIAS6   = 6'(EXP_BIAS);
  localparam logic [5:0] E_UNITY = 6'(EXP_BIAS + FRAC_W);
  localparam logic [5:0] E_MAX   = 6'd63;
  localparam logic [5:0] E_TOP   = 6'd62;

  state_t     state;
  logic       sign;
  logic [5:0] exp;
  logic [3:0] st_in;
  logic [1:0] path;
  logic [3:0] zst;

  logic [31:0] acc;
  logic        sticky;
  logic        sh_done;

  logic       accept;
  logic       frac_zero;
  logic [1:0] cls;
  logic [3:0] cls_zst;
  logic [4:0] n_load;
  logic       arm;

  assign in_ready  = (state == S_IDLE);
  assign state_dbg = state;
  assign accept    = in_valid && in_ready;
  assign frac_zero = (acc[FRAC_W-1:0] == '0);
  assign n_load    = (exp < E_UNITY) ? 5'(E_UNITY - exp)
                                     : 5'(exp - E_UNITY);
  assign arm = (state == S_CLASSIFY) && (cls == P_NORM);

  // Priority classification of the captured word.
  always_comb begin
    cls     = P_NORM;
    cls_zst = ST_EXACT;
    if (st_in == ST_OVF || exp == E_MAX ||
        (exp == E_TOP && !(sign && frac_zero))) begin
      cls = P_SAT;
    end else if (st_in == ST_UNF || exp == 6'd0) begin
      cls     = P_ZERO;
      cls_zst = (st_in == ST_UNF) ? ST_UNF : ST_EXACT;
    end else if (exp < BIAS6) begin
      cls     = P_ZERO;
      cls_zst = ST_UNF;
    end
  end

  fp_shift_unit u_shift (
    .clock_100kHz (clock_100kHz),
    .reset        (reset),
    .load         (accept),
    .acc_in       ({6'b0, 1'b1, data_in[FRAC_W-1:0]}),
    .arm          (arm),
    .cnt_in       (n_load),
    .dir_right    (exp < E_UNITY),
    .step         (state == S_SHIFT),
    .acc          (acc),
    .sticky       (sticky),
    .done         (sh_done)
  );

  // Conversion sequencer and output registers.
  always_ff @(posedge clock_100kHz or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sign       <= 1'b0;
      exp        <= '0;
      st_in      <= '0;
      path       <= P_NORM;
      zst        <= ST_EXACT;
      int_out    <= '0;
      status_out <= ST_EXACT;
      out_valid  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            sign  <= data_in[SIGN_BIT];
            exp   <= data_in[EXP_MSB:EXP_LSB];
            st_in <= status_in;
            state <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          path <= cls;
          zst  <= cls_zst;
          if (cls == P_NORM && n_load != 5'd0)
            state <= S_SHIFT;
          else
            state <= S_FINISH;
        end
        S_SHIFT: begin
          if (sh_done) state <= S_FINISH;
        end
        S_FINISH: begin
          unique case (path)
            P_SAT: begin
              int_out    <= sign ? 32'h8000_0000
                                 : 32'h7FFF_FFFF;
              status_out <= ST_OVF;
            end
            P_ZERO: begin
              int_out    <= '0;
              status_out <= zst;
            end
            default: begin
              int_out    <= sign ? (~acc + 32'd1) : acc;
              status_out <= sticky ? ST_INEXACT : ST_EXACT;
            end
          endcase
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_int_converter.sv
// Randomized and directed checks of fp_to_int_converter
// against an arithmetic reference model.
module tb_fp_to_int_converter;

  logic        clock_100kHz = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [3:0]  status_in;
  logic [31:0] int_out;
  logic [3:0]  status_out;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  fp_to_int_converter dut (
    .clock_100kHz (clock_100kHz),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .status_in    (status_in),
    .int_out      (int_out),
    .status_out   (status_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .state_dbg    (state_dbg)
  );

  always #5 clock_100kHz = ~clock_100kHz;

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // Value = (-1)^s * (2^25 + f) * 2^(e-56), truncated toward zero.
  task automatic model(input  logic [31:0] d,
                       input  logic [3:0]  st,
                       output logic [31:0] r,
                       output logic [3:0]  rs,
                       output int          lat);
    int     s, e, sh;
    longint mag, val;
    s   = int'(d[31]);
    e   = int'(d[30:25]);
    mag = longint'(d[24:0]) + (64'sd1 << 25);
    lat = 2;
    if (st == 4'd1 || e == 63 ||
        (e == 62 && !(s == 1 && d[24:0] == 0))) begin
      r  = (s == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      rs = 4'd1;
    end else if (st == 4'd2 || e == 0) begin
      r  = 0;
      rs = (st == 4'd2) ? 4'd2 : 4'd0;
    end else if (e < 31) begin
      r  = 0;
      rs = 4'd2;
    end else begin
      sh = e - 56;
      if (sh >= 0) begin
        val = mag * (64'sd1 << sh);
        rs  = 4'd0;
        lat = 2 + sh;
      end else begin
        val = mag / (64'sd1 << (-sh));
        rs  = (mag % (64'sd1 << (-sh)) != 0) ? 4'd3 : 4'd0;
        lat = 2 - sh;
      end
      if (s == 1) val = -val;
      r = val[31:0];
    end
  endtask

  task automatic release_out();
    @(negedge clock_100kHz);
    out_ready = 1'b1;
    @(posedge clock_100kHz);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag,
                     input logic [31:0] d,
                     input logic [3:0]  st,
                     input bit          rel);
    logic [31:0] er;
    logic [3:0]  es;
    int          el;
    int          n;
    model(d, st, er, es, el);
    @(negedge clock_100kHz);
    data_in   = d;
    status_in = st;
    in_valid  = 1'b1;
    @(posedge clock_100kHz);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clock_100kHz);
      #1;
      n++;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_lat"}, n, el);
      check({tag, "_int"}, int_out, er);
      check({tag, "_st"}, status_out, es);
    end
    if (rel) release_out();
  endtask

  logic [31:0] hold_int;
  logic [3:0]  hold_st;
  logic [31:0] rw;
  logic [3:0]  rst_in;
  int          seen;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    status_in = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock_100kHz);
    #1;
    check("rst_int", int_out, 0);
    check("rst_st", status_out, 0);
    check("rst_ov", out_valid, 0);
    check("rst_ir", in_ready, 1);
    check("rst_dbg", state_dbg, 0);
    @(negedge clock_100kHz);
    reset = 1'b0;

    run("one",   32'h3E00_0000, 4'd0, 1);
    run("five",  32'h4280_0000, 4'd0, 1);
    run("m2p5",  32'hC080_0000, 4'd0, 1);
    run("sat63", 32'h7E00_0000, 4'd0, 1);
    run("minint",32'hFC00_0000, 4'd0, 1);
    run("p2_31", 32'h7C00_0000, 4'd0, 1);
    run("ovfin", 32'h4280_0000, 4'd1, 1);
    run("ovfneg",32'hC280_0000, 4'd1, 1);
    run("half",  32'h3C00_0000, 4'd0, 1);
    run("zero",  32'h0000_0000, 4'd0, 1);
    run("unfin", 32'h4280_0000, 4'd2, 1);
    run("e56",   32'h7000_0001, 4'd0, 1);
    run("e61n",  32'hFBFF_FFFF, 4'd0, 1);
    check("idle_ir", in_ready, 1);

    // Backpressure: result held, second word ignored.
    run("bp", 32'hC280_0000, 4'd0, 0);
    hold_int = int_out;
    hold_st  = status_out;
    @(negedge clock_100kHz);
    data_in   = 32'h3E00_0000;
    status_in = 4'd0;
    in_valid  = 1'b1;
    repeat (10) begin
      @(posedge clock_100kHz);
      #1;
      check("bp_int", int_out, hold_int);
      check("bp_st", status_out, hold_st);
      check("bp_ir", in_ready, 0);
      check("bp_ov", out_valid, 1);
    end
    @(negedge clock_100kHz);
    in_valid = 1'b0;
    release_out();
    check("bp_idle", state_dbg, 0);
    run("bp_next", 32'h4280_0000, 4'd0, 1);

    // Reset while shifting aborts the conversion.
    @(negedge clock_100kHz);
    data_in   = 32'h3E00_0000;
    status_in = 4'd0;
    in_valid  = 1'b1;
    @(posedge clock_100kHz);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock_100kHz);
    #1;
    check("mid_dbg", state_dbg, 2);
    @(negedge clock_100kHz);
    reset = 1'b1;
    #1;
    check("ar_int", int_out, 0);
    check("ar_st", status_out, 0);
    check("ar_ov", out_valid, 0);
    check("ar_ir", in_ready, 1);
    check("ar_dbg", state_dbg, 0);
    @(negedge clock_100kHz);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clock_100kHz);
      #1;
      if (out_valid) seen++;
    end
    check("ar_noov", seen, 0);
    run("ar_next", 32'hC080_0000, 4'd0, 1);

    // Randomized words, biased toward the convertible exponents.
    for (int i = 0; i < 60; i++) begin
      rw = $urandom;
      if ($urandom_range(0, 3) != 0)
        rw[30:25] = 6'($urandom_range(28, 63));
      rst_in = ($urandom_range(0, 5) == 0)
             ? 4'($urandom_range(1, 3)) : 4'd0;
      run("rand", rw, rst_in, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
